// File: rtl/uart_prot_rx.sv
// rtl/uart_prot_rx.sv - 8N1 UART receiver feeding the protocol-trigger comparator
module uart_prot_rx #(
    parameter int DATA_W = 8,
    parameter int BAUD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RX,
    input  logic [BAUD_W-1:0] baud_cnt,
    output logic [DATA_W-1:0] serial_data,
    output logic              serial_vld,
    output logic              frm_err
);

    typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_W + 1);

    state_t            state, state_nxt;
    logic              rx_s1, rx_s2, rx_prev;
    logic              fall;
    logic [BAUD_W-1:0] bcnt, bcnt_nxt;
    logic [BAUD_W-1:0] baud_hold, baud_hold_nxt;
    logic [3:0]        bit_cnt, bit_cnt_nxt;
    logic [DATA_W:0]   shifter, shifter_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              vld_nxt, err_nxt;

    assign fall = rx_prev & ~rx_s2;

    always_comb begin
        state_nxt     = state;
        bcnt_nxt      = bcnt;
        baud_hold_nxt = baud_hold;
        bit_cnt_nxt   = bit_cnt;
        shifter_nxt   = shifter;
        data_nxt      = serial_data;
        vld_nxt       = 1'b0;
        err_nxt       = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt     = START;
                    bcnt_nxt      = baud_cnt >> 1;
                    baud_hold_nxt = baud_cnt;
                    bit_cnt_nxt   = 4'd0;
                end
            end
            START: begin
                if (bcnt == '0) begin
                    if (rx_s2) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt   = DATA;
                        // Reload one short so each bit spans exactly baud_hold clocks
                        bcnt_nxt    = baud_hold - BAUD_W'(1);
                        bit_cnt_nxt = 4'd1;
                    end
                end else begin
                    bcnt_nxt = bcnt - BAUD_W'(1);
                end
            end
            DATA: begin
                if (bcnt == '0) begin
                    shifter_nxt = {rx_s2, shifter[DATA_W:1]};
                    bcnt_nxt    = baud_hold - BAUD_W'(1);
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = DONE;
                    end
                end else begin
                    bcnt_nxt = bcnt - BAUD_W'(1);
                end
            end
            DONE: begin
                if (shifter[DATA_W]) begin
                    data_nxt = shifter[DATA_W-1:0];
                    vld_nxt  = 1'b1;
                end else begin
                    err_nxt = 1'b1;
                end
                state_nxt = IDLE;
                // A start edge landing in DONE begins the next frame with no dead time
                if (fall) begin
                    state_nxt     = START;
                    bcnt_nxt      = baud_cnt >> 1;
                    baud_hold_nxt = baud_cnt;
                    bit_cnt_nxt   = 4'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bcnt        <= '0;
            baud_hold   <= '0;
            bit_cnt     <= 4'd0;
            shifter     <= '0;
            serial_data <= '0;
            serial_vld  <= 1'b0;
            frm_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            bcnt        <= bcnt_nxt;
            baud_hold   <= baud_hold_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shifter     <= shifter_nxt;
            serial_data <= data_nxt;
            serial_vld  <= vld_nxt;
            frm_err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_prot_rx.sv
// tb/tb_uart_prot_rx.sv - directed self-checking bench for uart_prot_rx
module tb_uart_prot_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RX;
    logic [15:0] baud_cnt;
    logic [7:0]  serial_data;
    logic        serial_vld;
    logic        frm_err;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          vld_cnt = 0;
    int          err_cnt = 0;
    int          both_cnt = 0;
    int          long_cnt = 0;
    int          last_vld_cyc = 0;
    logic        prev_vld = 1'b0;
    logic        prev_err = 1'b0;
    logic [7:0]  rx_q[$];

    uart_prot_rx #(.DATA_W(8), .BAUD_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .baud_cnt    (baud_cnt),
        .serial_data (serial_data),
        .serial_vld  (serial_vld),
        .frm_err     (frm_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (serial_vld) begin
                vld_cnt      = vld_cnt + 1;
                last_vld_cyc = cyc;
                rx_q.push_back(serial_data);
            end
            if (frm_err) err_cnt = err_cnt + 1;
            if (serial_vld && frm_err) both_cnt = both_cnt + 1;
            if ((serial_vld && prev_vld) || (frm_err && prev_err)) long_cnt = long_cnt + 1;
        end
        prev_vld = serial_vld;
        prev_err = frm_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input int baud);
        RX = 1'b0;
        repeat (baud) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            repeat (baud) @(negedge clk);
        end
        RX = stop;
        repeat (baud) @(negedge clk);
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    int v0, e0, q0, fall_cyc, lat;

    initial begin
        rst_n    = 1'b0;
        RX       = 1'b1;
        baud_cnt = 16'd16;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(serial_data), 32'h00);
        check("rst_vld",  32'(serial_vld),  32'h0);
        check("rst_err",  32'(frm_err),     32'h0);
        rst_n = 1'b1;
        idle(5);

        // 1: single good frame and latency
        v0 = vld_cnt; e0 = err_cnt; q0 = rx_q.size();
        fall_cyc = cyc;
        send_byte(8'hA5, 1'b1, 16);
        idle(20);
        lat = last_vld_cyc - fall_cyc;
        check("t1_vld_cnt", 32'(vld_cnt - v0), 32'd1);
        check("t1_data", (rx_q.size() > q0) ? 32'(rx_q[q0]) : 32'hDEAD, 32'hA5);
        check("t1_err_cnt", 32'(err_cnt - e0), 32'd0);
        check("t1_latency_in_window", 32'(lat >= 150 && lat <= 160), 32'd1);

        // 2: back-to-back frames, no idle gap
        v0 = vld_cnt; q0 = rx_q.size();
        send_byte(8'h00, 1'b1, 16);
        send_byte(8'hFF, 1'b1, 16);
        idle(20);
        check("t2_vld_cnt", 32'(vld_cnt - v0), 32'd2);
        check("t2_data0", (rx_q.size() > q0) ? 32'(rx_q[q0]) : 32'hDEAD, 32'h00);
        check("t2_data1", (rx_q.size() > q0 + 1) ? 32'(rx_q[q0 + 1]) : 32'hDEAD, 32'hFF);

        // 3: stop bit forced low
        v0 = vld_cnt; e0 = err_cnt;
        send_byte(8'h3C, 1'b0, 16);
        idle(20);
        check("t3_err_cnt", 32'(err_cnt - e0), 32'd1);
        check("t3_vld_cnt", 32'(vld_cnt - v0), 32'd0);
        check("t3_data_kept", 32'(serial_data), 32'hFF);

        // 4: short glitch rejected, next frame good
        v0 = vld_cnt; e0 = err_cnt; q0 = rx_q.size();
        RX = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check("t4_glitch_no_vld", 32'(vld_cnt - v0), 32'd0);
        send_byte(8'h81, 1'b1, 16);
        idle(20);
        check("t4_vld_cnt", 32'(vld_cnt - v0), 32'd1);
        check("t4_err_cnt", 32'(err_cnt - e0), 32'd0);
        check("t4_data", (rx_q.size() > q0) ? 32'(rx_q[q0]) : 32'hDEAD, 32'h81);

        // 5: reset mid-frame
        v0 = vld_cnt; e0 = err_cnt; q0 = rx_q.size();
        RX = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RX = 8'h5A >> i;
            repeat (16) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("t5_rst_data", 32'(serial_data), 32'h00);
        check("t5_rst_vld",  32'(serial_vld),  32'h0);
        check("t5_rst_err",  32'(frm_err),     32'h0);
        RX = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        send_byte(8'hC3, 1'b1, 16);
        idle(20);
        check("t5_vld_cnt", 32'(vld_cnt - v0), 32'd1);
        check("t5_err_cnt", 32'(err_cnt - e0), 32'd0);
        check("t5_data", (rx_q.size() > q0) ? 32'(rx_q[q0]) : 32'hDEAD, 32'hC3);

        // 6: baud change mid-frame takes effect only on the next frame
        v0 = vld_cnt; q0 = rx_q.size();
        baud_cnt = 16'd16;
        fork
            send_byte(8'h96, 1'b1, 16);
            begin
                repeat (40) @(negedge clk);
                baud_cnt = 16'd32;
            end
        join
        idle(30);
        send_byte(8'h4B, 1'b1, 32);
        idle(40);
        check("t6_vld_cnt", 32'(vld_cnt - v0), 32'd2);
        check("t6_data0", (rx_q.size() > q0) ? 32'(rx_q[q0]) : 32'hDEAD, 32'h96);
        check("t6_data1", (rx_q.size() > q0 + 1) ? 32'(rx_q[q0 + 1]) : 32'hDEAD, 32'h4B);

        check("vld_err_overlap", 32'(both_cnt), 32'd0);
        check("pulse_width_1clk", 32'(long_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
